adder_share_arb: RTL

//  Round-robin arbiter and sequencer that shares one WIDTH-bit adder among 3 requesters.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/rr_arb3.sv | 37 +++
 rtl/adder_share_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the shared-adder arbiter.
// Contents:
//   NUM_REQ   - number of requesters sharing the adder
//   req_idx_t - requester index (0..NUM_REQ-1)
//   state_t   - sequencer FSM encoding
//   idx_add   - modulo-3 index rotation used by the round-robin scan
package adder_pkg;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // (base + off) mod 3, with base in 0..2 and off in 0..3.
    function automatic req_idx_t idx_add(input req_idx_t base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin pick.
// Ports:
//   i_req   - pending requests, one bit per requester
//   i_last  - index of the previously granted requester
//   o_grant - one-hot grant (all zero when no request is pending)
//   o_idx   - index of the granted requester (don't-care when o_grant is zero)
module rr_arb3
    import adder_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output req_idx_t           o_idx
);

    // Candidates in priority order: last+1, last+2, last+3 (mod 3).
    req_idx_t w_cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand[gi] = idx_add(i_last, 2'(gi + 1));
        end
    endgenerate

    always_comb begin
        o_grant = '0;
        o_idx   = i_last;
        // Walk from lowest to highest priority so the highest-priority hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_grant = NUM_REQ'(1) << w_cand[k];
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit adder among 3 requesters.
// One operation is in flight at a time: IDLE -> BUSY (LAT cycles) -> RESP -> IDLE.
// Ports:
//   CLK, RST_N     - clock and synchronous active-low reset
//   REQ            - level requests, held until ACK
//   IN_A, IN_B     - packed operands, requester i on [i*WIDTH +: WIDTH]
//   IN_CIN         - carry-in per requester
//   ACK            - one-cycle one-hot pulse in the first BUSY cycle
//   DONE           - one-cycle one-hot pulse in the RESP cycle
//   SUM, COUT      - result, held until the next DONE
//   BUSY           - high whenever the sequencer is not IDLE
// LAT must lie in 1..15.
module adder_share_arb
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*WIDTH-1:0]   IN_A,
    input  logic [NUM_REQ*WIDTH-1:0]   IN_B,
    input  logic [NUM_REQ-1:0]         IN_CIN,
    output logic [NUM_REQ-1:0]         ACK,
    output logic [NUM_REQ-1:0]         DONE,
    output logic [WIDTH-1:0]           SUM,
    output logic                       COUT,
    output logic                       BUSY
);

    state_t               r_state;
    req_idx_t             r_last;
    logic [3:0]           r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_cin;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_done;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_grant;
    req_idx_t             w_idx;
    logic [WIDTH:0]       w_sum_full;

    rr_arb3 u_arb (
        .i_req   (REQ),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Full-width add keeps the carry out of the top bit.
    assign w_sum_full = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_last  <= req_idx_t'(2);   // requester 0 scanned first after reset
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_ack   <= '0;
            r_done  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // ACK/DONE are single-cycle pulses unless re-armed below.
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|REQ) begin
                        // Operands are latched only here; later input changes are ignored.
                        r_a     <= IN_A[w_idx*WIDTH +: WIDTH];
                        r_b     <= IN_B[w_idx*WIDTH +: WIDTH];
                        r_cin   <= IN_CIN[w_idx];
                        r_last  <= w_idx;
                        r_cnt   <= 4'(LAT - 1);
                        r_ack   <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_done           <= NUM_REQ'(1) << r_last;
                        {r_cout, r_sum}  <= w_sum_full;
                        r_state          <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ACK  = r_ack;
    assign DONE = r_done;
    assign SUM  = r_sum;
    assign COUT = r_cout;
    assign BUSY = r_busy;

endmodule
